// File: rtl/mips_muldiv_seq.sv
// mips_muldiv_seq: sequential 32x32 signed multiply / divide, one bit per cycle.
// Define MULDIV_DIV_EN to build the divider; otherwise divide requests return the divide-by-zero result.
module mips_muldiv_seq #(
  parameter logic [4:0] FS_MUL = 5'h1E,
  parameter logic [4:0] FS_DIV = 5'h1F
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] mipsS,
  input  logic [31:0] mipsT,
  input  logic [4:0]  mipsFS,
  output logic        busy,
  output logic        done,
  output logic [31:0] Y_hi,
  output logic [31:0] Y_lo,
  output logic        N,
  output logic        Z,
  output logic        div0
);
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  state_t state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] p_q, p_d;
  logic [31:0] m_q, m_d;
  logic        neg_q, neg_d;
  logic [31:0] y_hi_q, y_hi_d, y_lo_q, y_lo_d;
  logic        n_q, n_d, z_q, z_d, div0_q, div0_d;
  logic [31:0] s_abs, t_abs;
  logic [32:0] sum;
  logic [63:0] mul_p, prod;
  assign s_abs = mipsS[31] ? -mipsS : mipsS;
  assign t_abs = mipsT[31] ? -mipsT : mipsT;
  // p holds {partial product, remaining multiplier bits}; magnitudes keep p[63] clear
  assign sum   = {1'b0, p_q[63:32]} + {1'b0, m_q};
  assign mul_p = p_q[0] ? {sum, p_q[31:1]} : {1'b0, p_q[63:1]};
  assign prod  = neg_q ? -p_q : p_q;
`ifdef MULDIV_DIV_EN
  logic        div_q, div_d, sneg_q, sneg_d;
  logic [32:0] diff;
  logic [63:0] div_p, run_p;
  logic [31:0] quo, rem;
  // p holds {partial remainder, dividend bits shifting out / quotient bits shifting in}
  assign diff  = {1'b0, p_q[62:31]} - {1'b0, m_q};
  assign div_p = diff[32] ? {p_q[62:0], 1'b0} : {diff[31:0], p_q[30:0], 1'b1};
  assign run_p = div_q ? div_p : mul_p;
  assign quo   = neg_q ? -p_q[31:0] : p_q[31:0];
  assign rem   = sneg_q ? -p_q[63:32] : p_q[63:32];
`else
  logic [63:0] run_p;
  assign run_p = mul_p;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    m_d     = m_q;
    neg_d   = neg_q;
    y_hi_d  = y_hi_q;
    y_lo_d  = y_lo_q;
    n_d     = n_q;
    z_d     = z_q;
    div0_d  = div0_q;
`ifdef MULDIV_DIV_EN
    div_d   = div_q;
    sneg_d  = sneg_q;
`endif
    case (state_q)
      IDLE: if (start && mipsFS == FS_MUL) begin
        state_d = RUN;
        cnt_d   = 5'd0;
        p_d     = {32'b0, t_abs};
        m_d     = s_abs;
        neg_d   = mipsS[31] ^ mipsT[31];
`ifdef MULDIV_DIV_EN
        div_d   = 1'b0;
`endif
      end else if (start && mipsFS == FS_DIV) begin
`ifdef MULDIV_DIV_EN
        if (mipsT == 32'd0) begin
          state_d = DONE;
          y_hi_d  = mipsS;
          y_lo_d  = '1;
          n_d     = 1'b1;
          z_d     = 1'b0;
          div0_d  = 1'b1;
        end else begin
          state_d = RUN;
          cnt_d   = 5'd0;
          p_d     = {32'b0, s_abs};
          m_d     = t_abs;
          neg_d   = mipsS[31] ^ mipsT[31];
          sneg_d  = mipsS[31];
          div_d   = 1'b1;
        end
`else
        state_d = DONE;
        y_hi_d  = '0;
        y_lo_d  = '1;
        n_d     = 1'b1;
        z_d     = 1'b0;
        div0_d  = 1'b1;
`endif
      end
      RUN: begin
        p_d     = run_p;
        cnt_d   = cnt_q + 5'd1;
        state_d = cnt_q == 5'd31 ? FIX : RUN;
      end
      FIX: begin
        state_d = DONE;
        div0_d  = 1'b0;
`ifdef MULDIV_DIV_EN
        y_hi_d  = div_q ? rem : prod[63:32];
        y_lo_d  = div_q ? quo : prod[31:0];
        n_d     = div_q ? quo[31] : prod[63];
        z_d     = div_q ? quo == 32'd0 : prod == 64'd0;
`else
        y_hi_d  = prod[63:32];
        y_lo_d  = prod[31:0];
        n_d     = prod[63];
        z_d     = prod == 64'd0;
`endif
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      m_q     <= '0;
      neg_q   <= 1'b0;
      y_hi_q  <= '0;
      y_lo_q  <= '0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
      div0_q  <= 1'b0;
`ifdef MULDIV_DIV_EN
      div_q   <= 1'b0;
      sneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      m_q     <= m_d;
      neg_q   <= neg_d;
      y_hi_q  <= y_hi_d;
      y_lo_q  <= y_lo_d;
      n_q     <= n_d;
      z_q     <= z_d;
      div0_q  <= div0_d;
`ifdef MULDIV_DIV_EN
      div_q   <= div_d;
      sneg_q  <= sneg_d;
`endif
    end
  end
  assign busy = state_q == RUN || state_q == FIX;
  assign done = state_q == DONE;
  assign Y_hi = y_hi_q;
  assign Y_lo = y_lo_q;
  assign N    = n_q;
  assign Z    = z_q;
  assign div0 = div0_q;
endmodule

// File: tb/tb_mips_muldiv_seq.sv
// tb_mips_muldiv_seq: scoreboard bench for mips_muldiv_seq; expectations come from a behavioural signed model.
module tb_mips_muldiv_seq;
  localparam logic [4:0] FM = 5'h1E;
  localparam logic [4:0] FD = 5'h1F;
  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0;
  logic [31:0] s_i = '0, t_i = '0;
  logic [4:0]  fs_i = '0;
  logic busy, done, n_o, z_o, div0_o;
  logic [31:0] y_hi, y_lo;
  typedef struct {logic [31:0] hi; logic [31:0] lo; logic n; logic z; logic d0; int lat;} exp_t;
  exp_t sb[$];
  int checks = 0, failures = 0;
  logic [31:0] last_hi = '0, last_lo = '0;

  mips_muldiv_seq #(.FS_MUL(FM), .FS_DIV(FD)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mipsS(s_i), .mipsT(t_i), .mipsFS(fs_i),
    .busy(busy), .done(done), .Y_hi(y_hi), .Y_lo(y_lo), .N(n_o), .Z(z_o), .div0(div0_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [4:0] fs, input logic [31:0] s, input logic [31:0] t);
    exp_t e;
    logic signed [63:0] p;
    logic signed [31:0] q, r;
    if (fs == FM) begin
      p = $signed({{32{s[31]}}, s}) * $signed({{32{t[31]}}, t});
      e = '{p[63:32], p[31:0], p[63], p == 0, 1'b0, 34};
    end else begin
`ifdef MULDIV_DIV_EN
      if (t == 0) e = '{s, '1, 1'b1, 1'b0, 1'b1, 1};
      else begin
        if (s == 32'h80000000 && t == 32'hFFFFFFFF) begin
          q = 32'sh80000000;
          r = 0;
        end else begin
          q = $signed(s) / $signed(t);
          r = $signed(s) % $signed(t);
        end
        e = '{r, q, q[31], q == 0, 1'b0, 34};
      end
`else
      e = '{32'd0, '1, 1'b1, 1'b0, 1'b1, 1};
`endif
    end
    return e;
  endfunction

  // inj >= 0: raise a divide-by-zero start that many cycles after accept, which must be ignored
  task automatic do_op(input logic [4:0] fs, input logic [31:0] s, input logic [31:0] t, input int inj);
    exp_t e;
    int lat;
    logic bz;
    sb.push_back(model(fs, s, t));
    @(negedge clk);
    start = 1'b1; fs_i = fs; s_i = s; t_i = t;
    @(posedge clk); #1;
    start = 1'b0; lat = 1; bz = 1'b1;
    while (!done && lat < 60) begin
      if (!busy) bz = 1'b0;
      start = (lat == inj);
      if (lat == inj) begin fs_i = FD; t_i = '0; end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    e = sb.pop_front();
    check("latency", lat, e.lat);
    check("busy_while_running", bz, 1'b1);
    check("busy_at_done", busy, 1'b0);
    check("Y_hi", y_hi, e.hi);
    check("Y_lo", y_lo, e.lo);
    check("N", n_o, e.n);
    check("Z", z_o, e.z);
    check("div0", div0_o, e.d0);
    last_hi = e.hi; last_lo = e.lo;
    start = 1'b1; fs_i = FM;
    @(posedge clk); #1;
    start = 1'b0;
    check("done_one_cycle", done, 1'b0);
    check("start_in_done_ignored", busy, 1'b0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_Y", {y_hi, y_lo}, 64'd0);
    check("rst_flags", {n_o, z_o, div0_o}, 3'b000);
    @(negedge clk);
    reset_n = 1'b1;
    do_op(FM, 32'd7, 32'hFFFFFFFD, -1);
    do_op(FM, 32'h80000000, 32'h80000000, -1);
    do_op(FM, 32'd0, 32'h12345678, -1);
    do_op(FM, 32'hFFFFFFFF, 32'hFFFFFFFF, -1);
    for (int i = 0; i < 4; i++) do_op(FM, $urandom, $urandom, -1);
    do_op(FD, 32'hFFFFFFF9, 32'd2, -1);
    do_op(FD, 32'd5, 32'd0, -1);
    do_op(FD, 32'h80000000, 32'hFFFFFFFF, -1);
    do_op(FD, 32'd7, 32'hFFFFFFFE, -1);
    do_op(FD, 32'd3, 32'd10, -1);
    do_op(FD, 32'd100, 32'h80000000, -1);
    for (int i = 0; i < 4; i++) do_op(FD, $urandom, $urandom_range(1, 1000), -1);
    do_op(FM, 32'd3, 32'd4, 10);
    @(negedge clk);
    start = 1'b1; fs_i = 5'h05;
    repeat (3) @(posedge clk);
    #1;
    check("bad_fs_busy", busy, 1'b0);
    check("bad_fs_done", done, 1'b0);
    check("bad_fs_hold", {y_hi, y_lo}, {last_hi, last_lo});
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; fs_i = FM; s_i = 32'd3; t_i = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    check("pre_rst_busy", busy, 1'b1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_Y", {y_hi, y_lo}, 64'd0);
    check("mid_rst_flags", {n_o, z_o, div0_o}, 3'b000);
    @(negedge clk);
    reset_n = 1'b1;
    do_op(FM, 32'd2, 32'd2, -1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mips_muldiv_seq.md
MIPS_MULDIV_SEQ -- requirements
Module: mips_muldiv_seq

Interface
REQ-001 The block SHALL have parameter FS_MUL, default 5'h1E, the function-select code that requests a multiply.
REQ-002 The block SHALL have parameter FS_DIV, default 5'h1F, the function-select code that requests a divide.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port start, input, 1 bit: request to begin an operation.
REQ-006 Port mipsS, input, 32 bits: multiplicand or dividend, two's complement.
REQ-007 Port mipsT, input, 32 bits: multiplier or divisor, two's complement.
REQ-008 Port mipsFS, input, 5 bits: operation select.
REQ-009 Port busy, output, 1 bit: an operation is in progress.
REQ-010 Port done, output, 1 bit: one-cycle pulse marking valid results.
REQ-011 Port Y_hi, output, 32 bits: MUL gives product[63:32]; DIV gives the remainder.
REQ-012 Port Y_lo, output, 32 bits: MUL gives product[31:0]; DIV gives the quotient.
REQ-013 Ports N, Z, div0, outputs, 1 bit each: negative, zero and divide-by-zero status flags.

Function
REQ-014 The FSM SHALL have four states: IDLE, RUN, FIX and DONE.
REQ-015 The block SHALL accept start only in IDLE and only when mipsFS equals FS_MUL or FS_DIV; other codes SHALL be ignored and the block stays in IDLE.
REQ-016 On the accept edge the block SHALL latch the operation and operand magnitudes, record the result sign, clear the 5-bit iteration counter and enter RUN.
REQ-017 RUN SHALL last exactly 32 cycles, processing one bit per cycle: shift-add for MUL, restoring subtract-shift for DIV; it then enters FIX.
REQ-018 FIX SHALL last 1 cycle: it applies the two's-complement sign correction and registers Y_hi, Y_lo, N, Z and div0, then enters DONE.
REQ-019 DONE SHALL last 1 cycle with done=1, then return to IDLE; latency from the accept edge to done high is 34 clocks.
REQ-020 busy SHALL be 1 in RUN and FIX and 0 in IDLE and DONE.
REQ-021 start SHALL be ignored outside IDLE, including during the DONE cycle.
REQ-022 Y_hi, Y_lo, N, Z and div0 SHALL hold their values until the FIX or divide-by-zero update of the next accepted operation.
REQ-023 MUL SHALL produce the full 64-bit signed product; it cannot overflow.
REQ-024 DIV SHALL truncate the quotient toward zero, and the remainder SHALL take the sign of the dividend.
REQ-025 For DIV 32'h80000000 / 32'hFFFFFFFF the block SHALL give Y_lo=32'h80000000 and Y_hi=0, with no error flag.
REQ-026 For DIV with mipsT=0 at accept, the block SHALL skip RUN and FIX and go directly to DONE on the next edge, with Y_hi=mipsS, Y_lo=32'hFFFFFFFF, div0=1 (latency 1 clock).
REQ-027 div0 SHALL be 0 for every other completed operation.
REQ-028 For MUL, N SHALL equal Y_hi[31] and Z SHALL be 1 iff all 64 result bits are 0.
REQ-029 For DIV, N SHALL equal Y_lo[31] and Z SHALL be 1 iff Y_lo==0.

Reset
REQ-030 When reset_n=0 the block SHALL immediately enter IDLE and clear busy, done, Y_hi, Y_lo, N, Z, div0 and the counter to 0, including mid-operation.
REQ-031 After reset_n is released, the first rising edge with a valid start SHALL be accepted normally.

Configuration
REQ-032 With macro MULDIV_DIV_EN defined, divide SHALL be implemented exactly as specified above.
REQ-033 With MULDIV_DIV_EN undefined, no divide datapath SHALL exist, and FS_DIV SHALL be handled like divide-by-zero (DONE next edge) with Y_hi=0, Y_lo=32'hFFFFFFFF, div0=1.

Verification
REQ-034 MUL 32'd7 x 32'hFFFFFFFD -> done at accept+34, Y_hi=32'hFFFFFFFF, Y_lo=32'hFFFFFFEB, N=1, Z=0.
REQ-035 MUL 32'h80000000 x 32'h80000000 -> Y_hi=32'h40000000, Y_lo=0, N=0, Z=0.
REQ-036 DIV 32'hFFFFFFF9 / 32'd2 -> Y_lo=32'hFFFFFFFD, Y_hi=32'hFFFFFFFF, N=1, div0=0.
REQ-037 DIV 32'd5 / 0 -> done 1 clock after accept, Y_hi=32'd5, Y_lo=32'hFFFFFFFF, div0=1.
REQ-038 MUL 3x4 accepted, then a second start at cycle 10 with DIV -> second start ignored, Y_lo=32'd12 at accept+34, busy stays high until then.
REQ-039 reset_n=0 in RUN cycle 15 -> busy=0, done=0 and all outputs 0 immediately; a new MUL 2x2 completes with Y_lo=4.
